// File: rtl/sdram_arb_pkg.sv
// Shared types for the SDRAM port arbiter: FSM states, port indices and
// helpers to convert between a port index and its one-hot grant bit.
package sdram_arb_pkg;

  localparam int NUM_PORTS = 3;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_DATA = 2'd2,
    DONE      = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    PORT_PLAY = 2'd0,
    PORT_REC  = 2'd1,
    PORT_CTL  = 2'd2
  } port_e;

  function automatic port_e onehot_to_port(input logic [NUM_PORTS-1:0] oh);
    port_e p;
    if (oh[1])      p = PORT_REC;
    else if (oh[2]) p = PORT_CTL;
    else            p = PORT_PLAY;
    return p;
  endfunction

  function automatic logic [NUM_PORTS-1:0] port_to_onehot(input port_e p);
    logic [NUM_PORTS-1:0] v;
    v    = '0;
    v[p] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/rr_arbiter3.sv
// Three-way round-robin selector: the port after the last granted one has
// the highest priority, the last granted one the lowest.
module rr_arbiter3
  import sdram_arb_pkg::*;
(
  input  logic [NUM_PORTS-1:0] i_req,
  input  port_e                i_last,
  output logic [NUM_PORTS-1:0] o_grant
);

  always_comb begin
    o_grant = '0;
    case (i_last)
      PORT_PLAY: begin
        if (i_req[1])      o_grant = 3'b010;
        else if (i_req[2]) o_grant = 3'b100;
        else if (i_req[0]) o_grant = 3'b001;
      end
      PORT_REC: begin
        if (i_req[2])      o_grant = 3'b100;
        else if (i_req[0]) o_grant = 3'b001;
        else if (i_req[1]) o_grant = 3'b010;
      end
      default: begin
        if (i_req[0])      o_grant = 3'b001;
        else if (i_req[1]) o_grant = 3'b010;
        else if (i_req[2]) o_grant = 3'b100;
      end
    endcase
  end

endmodule

// File: rtl/sdram_arbiter.sv
// Shares one Avalon-MM SDRAM master among play (read), record (write) and
// control (read/write) ports; one command in flight, round-robin grants.
module sdram_arbiter
  import sdram_arb_pkg::*;
#(
  parameter int ADDR_W = 23,
  parameter int DATA_W = 32
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              play_read,
  input  logic [ADDR_W-1:0] play_addr,
  output logic [DATA_W-1:0] play_readdata,
  output logic              play_finished,
  input  logic              rec_write,
  input  logic [ADDR_W-1:0] rec_addr,
  input  logic [DATA_W-1:0] rec_writedata,
  output logic              rec_finished,
  input  logic              ctl_read,
  input  logic              ctl_write,
  input  logic [ADDR_W-1:0] ctl_addr,
  input  logic [DATA_W-1:0] ctl_writedata,
  output logic [DATA_W-1:0] ctl_readdata,
  output logic              ctl_finished,
  output logic [ADDR_W-1:0] sdram_addr,
  output logic [DATA_W-1:0] sdram_writedata,
  output logic              sdram_read,
  output logic              sdram_write,
  input  logic [DATA_W-1:0] sdram_readdata,
  input  logic              sdram_waitrequest,
  input  logic              sdram_readdatavalid
);

  state_e               state_q, state_d;
  port_e                last_q, last_d;
  port_e                gnt_q, gnt_d;
  port_e                sel;
  logic                 is_write_q, is_write_d;
  logic [ADDR_W-1:0]    addr_q, addr_d;
  logic [DATA_W-1:0]    wdata_q, wdata_d;
  logic [DATA_W-1:0]    rdata_q, rdata_d;
  logic                 sdram_read_q, sdram_read_d;
  logic                 sdram_write_q, sdram_write_d;
  logic [NUM_PORTS-1:0] fin_q, fin_d;
  logic [NUM_PORTS-1:0] req, grant;

  // A control request with both strobes high is treated as a read.
  assign req = {ctl_read | ctl_write, rec_write, play_read};

  rr_arbiter3 u_rr (
    .i_req   (req),
    .i_last  (last_q),
    .o_grant (grant)
  );

  always_comb begin
    state_d       = state_q;
    last_d        = last_q;
    gnt_d         = gnt_q;
    is_write_d    = is_write_q;
    addr_d        = addr_q;
    wdata_d       = wdata_q;
    rdata_d       = rdata_q;
    sdram_read_d  = 1'b0;
    sdram_write_d = 1'b0;
    fin_d         = '0;
    sel           = onehot_to_port(grant);
    case (state_q)
      IDLE: begin
        if (|grant) begin
          gnt_d   = sel;
          last_d  = sel;
          state_d = ISSUE;
          case (sel)
            PORT_PLAY: begin
              addr_d     = play_addr;
              is_write_d = 1'b0;
            end
            PORT_REC: begin
              addr_d     = rec_addr;
              wdata_d    = rec_writedata;
              is_write_d = 1'b1;
            end
            default: begin
              addr_d     = ctl_addr;
              wdata_d    = ctl_writedata;
              is_write_d = ctl_write & ~ctl_read;
            end
          endcase
          sdram_write_d = is_write_d;
          sdram_read_d  = ~is_write_d;
        end
      end
      ISSUE: begin
        if (sdram_waitrequest) begin
          sdram_read_d  = sdram_read_q;
          sdram_write_d = sdram_write_q;
        end else if (is_write_q) begin
          state_d = DONE;
          fin_d   = port_to_onehot(gnt_q);
        end else begin
          state_d = WAIT_DATA;
        end
      end
      WAIT_DATA: begin
        if (sdram_readdatavalid) begin
          rdata_d = sdram_readdata;
          state_d = DONE;
          fin_d   = port_to_onehot(gnt_q);
        end
      end
      DONE: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q       <= IDLE;
      last_q        <= PORT_CTL;
      gnt_q         <= PORT_PLAY;
      is_write_q    <= 1'b0;
      addr_q        <= '0;
      wdata_q       <= '0;
      rdata_q       <= '0;
      sdram_read_q  <= 1'b0;
      sdram_write_q <= 1'b0;
      fin_q         <= '0;
    end else begin
      state_q       <= state_d;
      last_q        <= last_d;
      gnt_q         <= gnt_d;
      is_write_q    <= is_write_d;
      addr_q        <= addr_d;
      wdata_q       <= wdata_d;
      rdata_q       <= rdata_d;
      sdram_read_q  <= sdram_read_d;
      sdram_write_q <= sdram_write_d;
      fin_q         <= fin_d;
    end
  end

  assign sdram_addr      = addr_q;
  assign sdram_writedata = wdata_q;
  assign sdram_read      = sdram_read_q;
  assign sdram_write     = sdram_write_q;
  assign play_readdata   = rdata_q;
  assign ctl_readdata    = rdata_q;
  assign play_finished   = fin_q[PORT_PLAY];
  assign rec_finished    = fin_q[PORT_REC];
  assign ctl_finished    = fin_q[PORT_CTL];

endmodule

// File: tb/tb_sdram_arbiter.sv
// Directed scenarios plus a randomized run against a transaction-level model
// (round-robin pick, Avalon handshake timing, reference memory).
module tb_sdram_arbiter;
  localparam int AW = 23;
  localparam int DW = 32;

  logic          i_clk = 1'b0;
  logic          i_rst;
  logic          play_read, rec_write, ctl_read, ctl_write;
  logic [AW-1:0] play_addr, rec_addr, ctl_addr;
  logic [DW-1:0] rec_writedata, ctl_writedata;
  logic [DW-1:0] play_readdata, ctl_readdata;
  logic          play_finished, rec_finished, ctl_finished;
  logic [AW-1:0] sdram_addr;
  logic [DW-1:0] sdram_writedata, sdram_readdata;
  logic          sdram_read, sdram_write, sdram_waitrequest, sdram_readdatavalid;

  logic          auto_rsp;
  logic          d_wait, d_valid, a_wait, a_valid;
  logic [DW-1:0] d_data, a_data;
  logic [DW-1:0] sdram_mem [16];
  logic [DW-1:0] ref_mem [16];
  logic [3:0]    rd_addr;
  int            rd_lat;

  int vectors = 0;
  int errors  = 0;

  always #5 i_clk = ~i_clk;

  assign sdram_waitrequest   = auto_rsp ? a_wait  : d_wait;
  assign sdram_readdatavalid = auto_rsp ? a_valid : d_valid;
  assign sdram_readdata      = auto_rsp ? a_data  : d_data;

  wire any_out = |{sdram_read, sdram_write, sdram_addr, sdram_writedata, play_readdata,
                   ctl_readdata, play_finished, rec_finished, ctl_finished};
  wire [2:0] fin_vec = {ctl_finished, rec_finished, play_finished};

  sdram_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .play_read(play_read), .play_addr(play_addr), .play_readdata(play_readdata),
    .play_finished(play_finished),
    .rec_write(rec_write), .rec_addr(rec_addr), .rec_writedata(rec_writedata),
    .rec_finished(rec_finished),
    .ctl_read(ctl_read), .ctl_write(ctl_write), .ctl_addr(ctl_addr),
    .ctl_writedata(ctl_writedata), .ctl_readdata(ctl_readdata), .ctl_finished(ctl_finished),
    .sdram_addr(sdram_addr), .sdram_writedata(sdram_writedata),
    .sdram_read(sdram_read), .sdram_write(sdram_write),
    .sdram_readdata(sdram_readdata), .sdram_waitrequest(sdram_waitrequest),
    .sdram_readdatavalid(sdram_readdatavalid)
  );

  // Automatic SDRAM slave: random waitrequest, read latency 1..3 cycles.
  always @(negedge i_clk) begin
    a_valid = 1'b0;
    if (i_rst || !auto_rsp) begin
      rd_lat = 0;
      a_wait = 1'b0;
    end else begin
      if (rd_lat > 0) begin
        rd_lat--;
        if (rd_lat == 0) begin
          a_valid = 1'b1;
          a_data  = sdram_mem[rd_addr];
        end
      end
      a_wait = ($urandom_range(0, 2) == 0);
      if (sdram_write && !a_wait) sdram_mem[sdram_addr[3:0]] = sdram_writedata;
      if (sdram_read && !a_wait) begin
        rd_lat  = $urandom_range(1, 3);
        rd_addr = sdram_addr[3:0];
      end
    end
  end

  task automatic step();
    @(negedge i_clk);
    #1;
  endtask

  task automatic clr_inputs();
    play_read = 0; rec_write = 0; ctl_read = 0; ctl_write = 0;
    play_addr = '0; rec_addr = '0; ctl_addr = '0;
    rec_writedata = '0; ctl_writedata = '0;
    d_wait = 0; d_valid = 0; d_data = '0;
  endtask

  task automatic do_reset();
    auto_rsp = 0;
    clr_inputs();
    i_rst = 1;
    step();
    step();
    i_rst = 0;
    step();
  endtask

  task automatic test_reset();
    auto_rsp = 0;
    clr_inputs();
    i_rst = 1;
    #1;
    vectors++;
    if (any_out !== 1'b0) begin
      errors++; $display("FAIL reset_outputs: got any_out=%b required 0", any_out);
    end
    step();
    i_rst = 0;
    step();
    vectors++;
    if (any_out !== 1'b0) begin
      errors++; $display("FAIL reset_idle: got any_out=%b required 0", any_out);
    end
  endtask

  task automatic test_play_read();
    do_reset();
    play_read = 1; play_addr = 23'h000010;
    step();
    vectors++;
    if ({sdram_read, sdram_write, sdram_addr, play_finished} !== {1'b1, 1'b0, 23'h000010, 1'b0}) begin
      errors++; $display("FAIL play_cmd: got rd=%b wr=%b addr=%h fin=%b required 1 0 000010 0",
                         sdram_read, sdram_write, sdram_addr, play_finished);
    end
    d_valid = 1; d_data = 32'h0BAD0BAD;
    step();
    vectors++;
    if ({sdram_read, sdram_write, play_finished} !== 3'b000) begin
      errors++; $display("FAIL play_wait: got rd=%b wr=%b fin=%b required 000",
                         sdram_read, sdram_write, play_finished);
    end
    d_valid = 1; d_data = 32'hDEADBEEF;
    step();
    vectors++;
    if ({fin_vec, play_readdata, ctl_readdata} !== {3'b001, 32'hDEADBEEF, 32'hDEADBEEF}) begin
      errors++; $display("FAIL play_done: got fin=%b rd=%h/%h required 001 deadbeef",
                         fin_vec, play_readdata, ctl_readdata);
    end
    play_read = 0; d_valid = 0;
    step();
    vectors++;
    if ({fin_vec, play_readdata} !== {3'b000, 32'hDEADBEEF}) begin
      errors++; $display("FAIL play_after: got fin=%b data=%h required 000 deadbeef",
                         fin_vec, play_readdata);
    end
  endtask

  task automatic test_rec_write_wait();
    do_reset();
    rec_write = 1; rec_addr = 23'h000020; rec_writedata = 32'h12345678;
    for (int k = 1; k <= 4; k++) begin
      step();
      d_wait = (k < 4);
      vectors++;
      if ({sdram_write, sdram_read, sdram_addr, sdram_writedata, rec_finished} !==
          {1'b1, 1'b0, 23'h000020, 32'h12345678, 1'b0}) begin
        errors++; $display("FAIL rec_hold c%0d: got wr=%b rd=%b addr=%h data=%h fin=%b required 1 0 000020 12345678 0",
                           k, sdram_write, sdram_read, sdram_addr, sdram_writedata, rec_finished);
      end
      rec_addr = AW'($urandom); rec_writedata = $urandom;
    end
    step();
    d_wait = 0;
    vectors++;
    if ({sdram_write, fin_vec} !== {1'b0, 3'b010}) begin
      errors++; $display("FAIL rec_done: got wr=%b fin=%b required 0 010", sdram_write, fin_vec);
    end
    rec_write = 0;
    step();
    vectors++;
    if (fin_vec !== 3'b000) begin
      errors++; $display("FAIL rec_pulse_len: got fin=%b required 000", fin_vec);
    end
  endtask

  task automatic test_round_robin();
    int order[$];
    int exp_order[6] = '{0, 1, 2, 0, 1, 2};
    do_reset();
    auto_rsp = 1;
    play_read = 1; play_addr = 23'h1;
    rec_write = 1; rec_addr = 23'h2; rec_writedata = 32'hA5A5A5A5;
    ctl_write = 1; ctl_addr = 23'h3; ctl_writedata = 32'h5A5A5A5A;
    for (int c = 0; c < 300 && order.size() < 6; c++) begin
      step();
      if (fin_vec == 3'b001) order.push_back(0);
      else if (fin_vec == 3'b010) order.push_back(1);
      else if (fin_vec == 3'b100) order.push_back(2);
    end
    vectors++;
    if (order.size() != 6) begin
      errors++; $display("FAIL rr_timeout: got %0d grants required 6", order.size());
    end
    for (int i = 0; i < order.size(); i++) begin
      vectors++;
      if (order[i] != exp_order[i]) begin
        errors++; $display("FAIL rr_order[%0d]: got port %0d required %0d", i, order[i], exp_order[i]);
      end
    end
    clr_inputs();
    auto_rsp = 0;
  endtask

  task automatic test_ctl_both();
    logic [DW-1:0] rd;
    rd = $urandom;
    do_reset();
    ctl_read = 1; ctl_write = 1; ctl_addr = 23'h7FFFFF; ctl_writedata = 32'hFFFF0000;
    step();
    vectors++;
    if ({sdram_read, sdram_write, sdram_addr} !== {1'b1, 1'b0, 23'h7FFFFF}) begin
      errors++; $display("FAIL ctl_both_cmd: got rd=%b wr=%b addr=%h required 1 0 7fffff",
                         sdram_read, sdram_write, sdram_addr);
    end
    step();
    d_valid = 1; d_data = rd;
    vectors++;
    if ({sdram_read, sdram_write} !== 2'b00) begin
      errors++; $display("FAIL ctl_both_wait: got rd=%b wr=%b required 00", sdram_read, sdram_write);
    end
    step();
    d_valid = 0;
    vectors++;
    if ({fin_vec, ctl_readdata} !== {3'b100, rd}) begin
      errors++; $display("FAIL ctl_both_done: got fin=%b data=%h required 100 %h", fin_vec, ctl_readdata, rd);
    end
    clr_inputs();
    step();
  endtask

  task automatic test_drop();
    logic [DW-1:0] rd, wd;
    rd = $urandom; wd = $urandom;
    do_reset();
    play_read = 1; play_addr = 23'h5;
    ctl_write = 1; ctl_addr = 23'h9; ctl_writedata = wd;
    step();
    vectors++;
    if ({sdram_read, sdram_addr} !== {1'b1, 23'h5}) begin
      errors++; $display("FAIL drop_cmd: got rd=%b addr=%h required 1 000005", sdram_read, sdram_addr);
    end
    play_read = 0;
    step();
    d_valid = 1; d_data = rd;
    step();
    d_valid = 0;
    vectors++;
    if ({fin_vec, play_readdata} !== {3'b001, rd}) begin
      errors++; $display("FAIL drop_done: got fin=%b data=%h required 001 %h", fin_vec, play_readdata, rd);
    end
    step();
    vectors++;
    if ({sdram_read, sdram_write, fin_vec} !== 5'b0) begin
      errors++; $display("FAIL drop_idle: got rd=%b wr=%b fin=%b required 0 0 000", sdram_read, sdram_write, fin_vec);
    end
    step();
    vectors++;
    if ({sdram_write, sdram_read, sdram_addr, sdram_writedata} !== {1'b1, 1'b0, 23'h9, wd}) begin
      errors++; $display("FAIL drop_ctl_cmd: got wr=%b rd=%b addr=%h data=%h required 1 0 000009 %h",
                         sdram_write, sdram_read, sdram_addr, sdram_writedata, wd);
    end
    step();
    ctl_write = 0;
    vectors++;
    if (fin_vec !== 3'b100) begin
      errors++; $display("FAIL drop_ctl_done: got fin=%b required 100", fin_vec);
    end
    step();
  endtask

  task automatic test_reset_mid();
    do_reset();
    play_read = 1; play_addr = 23'h3;
    step();
    step();
    vectors++;
    if (sdram_read !== 1'b0) begin
      errors++; $display("FAIL mid_waitdata: got rd=%b required 0", sdram_read);
    end
    i_rst = 1; play_read = 0;
    #1;
    vectors++;
    if (any_out !== 1'b0) begin
      errors++; $display("FAIL mid_reset_outputs: got any_out=%b required 0", any_out);
    end
    step();
    i_rst = 0;
    d_valid = 1; d_data = 32'hCAFEF00D;
    for (int c = 0; c < 3; c++) begin
      step();
      d_valid = 0;
      vectors++;
      if (any_out !== 1'b0) begin
        errors++; $display("FAIL mid_late_valid c%0d: got fin=%b data=%h required all zero",
                           c, fin_vec, play_readdata);
      end
    end
  endtask

  task automatic test_random();
    logic          act [3];
    logic [AW-1:0] paddr [3];
    logic [DW-1:0] pdata [3];
    logic          pwr [3];
    int            pmode;
    logic [2:0]    prev_req, exp_fin_vec, one3;
    int            last, cur_p, exp_p, n_fin;
    logic          cmd_prev, cmd, prev_wr_acc, prev_rv, exp_fin, cur_wr;
    logic [AW-1:0] cur_addr;
    logic [DW-1:0] cur_data;
    do_reset();
    for (int i = 0; i < 16; i++) begin
      sdram_mem[i] = $urandom;
      ref_mem[i]   = sdram_mem[i];
    end
    for (int p = 0; p < 3; p++) act[p] = 0;
    one3 = 3'b001; pmode = 0;
    prev_req = '0; last = 2; cur_p = 0; n_fin = 0;
    cmd_prev = 0; prev_wr_acc = 0; prev_rv = 0; cur_wr = 0; cur_addr = '0; cur_data = '0;
    auto_rsp = 1;
    for (int c = 0; c < 3000; c++) begin
      step();
      cmd = sdram_read | sdram_write;
      vectors++;
      if (sdram_read && sdram_write) begin
        errors++; $display("FAIL rnd_both_cmds c%0d: got rd=1 wr=1 required at most one", c);
      end
      if (cmd && !cmd_prev) begin
        exp_p = -1;
        for (int k = 1; k <= 3 && exp_p < 0; k++)
          if (prev_req[(last + k) % 3]) exp_p = (last + k) % 3;
        vectors++;
        if (exp_p < 0) begin
          errors++; $display("FAIL rnd_spurious_cmd c%0d: got command with no request", c);
        end else begin
          cur_p = exp_p; last = exp_p;
          cur_wr = pwr[exp_p]; cur_addr = paddr[exp_p]; cur_data = pdata[exp_p];
          if ({sdram_write, sdram_addr} !== {cur_wr, cur_addr} ||
              (cur_wr && sdram_writedata !== cur_data)) begin
            errors++; $display("FAIL rnd_grant c%0d: got wr=%b addr=%h data=%h required port %0d wr=%b addr=%h data=%h",
                               c, sdram_write, sdram_addr, sdram_writedata, exp_p, cur_wr, cur_addr, cur_data);
          end
        end
      end
      exp_fin = prev_wr_acc || prev_rv;
      exp_fin_vec = exp_fin ? (one3 << cur_p) : 3'b000;
      vectors++;
      if (fin_vec !== exp_fin_vec) begin
        errors++; $display("FAIL rnd_finished c%0d: got %b required %b", c, fin_vec, exp_fin_vec);
      end
      if (exp_fin) begin
        n_fin++;
        if (cur_wr) ref_mem[cur_addr[3:0]] = cur_data;
        else begin
          vectors++;
          if (play_readdata !== ref_mem[cur_addr[3:0]] || ctl_readdata !== ref_mem[cur_addr[3:0]]) begin
            errors++; $display("FAIL rnd_readdata c%0d: got %h/%h required %h",
                               c, play_readdata, ctl_readdata, ref_mem[cur_addr[3:0]]);
          end
        end
      end
      prev_wr_acc = sdram_write && !sdram_waitrequest;
      prev_rv     = sdram_readdatavalid;
      cmd_prev    = cmd;
      for (int p = 0; p < 3; p++) begin
        if (fin_vec[p]) act[p] = ($urandom_range(0, 1) == 1);
        else if (!act[p]) act[p] = ($urandom_range(0, 3) == 0);
        if (act[p] && (fin_vec[p] || !prev_req[p])) begin
          paddr[p] = AW'($urandom_range(0, 15));
          pdata[p] = $urandom;
          if (p == 0) pwr[p] = 0;
          else if (p == 1) pwr[p] = 1;
          else begin
            pmode  = $urandom_range(0, 2);
            pwr[p] = (pmode == 1);
          end
        end
      end
      play_read = act[0]; play_addr = paddr[0];
      rec_write = act[1]; rec_addr = paddr[1]; rec_writedata = pdata[1];
      ctl_read  = act[2] && (pmode != 1);
      ctl_write = act[2] && (pmode != 0);
      ctl_addr  = paddr[2]; ctl_writedata = pdata[2];
      prev_req  = {act[2], act[1], act[0]};
    end
    vectors++;
    if (n_fin < 100) begin
      errors++; $display("FAIL rnd_throughput: got %0d completions required at least 100", n_fin);
    end
    clr_inputs();
    auto_rsp = 0;
  endtask

  initial begin
    auto_rsp = 0;
    a_wait = 0; a_valid = 0; a_data = '0; rd_lat = 0; rd_addr = '0;
    for (int i = 0; i < 16; i++) sdram_mem[i] = '0;
    clr_inputs();
    i_rst = 1;
    test_reset();
    test_play_read();
    test_rec_write_wait();
    test_round_robin();
    test_ctl_both();
    test_drop();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
